// File: rtl/ushift_pkg.sv
// Shared types for the ushift_reg universal shift register: S-mode encoding,
// burst FSM states and burst direction constants.
package ushift_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'b00,
    SHL_MSB = 2'b01,
    SHR_LSB = 2'b10,
    LOAD    = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB = 1'b0;
  localparam logic DIR_LSB = 1'b1;

endpackage

// File: rtl/ushift_if.sv
// Control/status bundle of ushift_reg; the parallel IO bus stays a plain
// inout port on the top because it is a resolved tristate net.
interface ushift_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [1:0]    S;
  logic [1:0]    N_OE;
  logic          DSL;
  logic          DSR;
  logic          ROT;
  logic          START;
  logic          DIR;
  logic [CW-1:0] CNT;
  logic          Q0;
  logic          QMSB;
  logic          BUSY;
  logic          DONE;

  modport master (
    output S, N_OE, DSL, DSR, ROT, START, DIR, CNT,
    input  Q0, QMSB, BUSY, DONE
  );

  modport slave (
    input  S, N_OE, DSL, DSR, ROT, START, DIR, CNT,
    output Q0, QMSB, BUSY, DONE
  );

endinterface

// File: rtl/ushift_burst_ctrl.sv
// Counted burst-shift engine: accepts START in IDLE, issues one shift enable
// per cycle for CNT cycles, and reports BUSY plus a one-cycle DONE pulse.
module ushift_burst_ctrl
  import ushift_pkg::*;
#(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          dir,
  input  logic [CW-1:0] cnt,
  output logic          busy,
  output logic          done,
  output logic          engaged,
  output logic          shift_en,
  output logic          shift_dir
);

  state_e        state, state_next;
  logic [CW-1:0] count, count_next;
  logic          dir_lat, dir_next;
  logic          done_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      dir_lat <= DIR_MSB;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      dir_lat <= dir_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    dir_next   = dir_lat;
    done_next  = 1'b0;
    shift_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          count_next = cnt;
          dir_next   = dir;
          // A zero-length burst completes immediately without touching the register
          if (cnt == '0) done_next = 1'b1;
          else           state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en   = 1'b1;
        count_next = count - CW'(1);
        if (count == CW'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state == SHIFT);
  // The engine owns the register on the accept edge too, so S is ignored there
  assign engaged   = busy || start;
  assign shift_dir = dir_lat;

endmodule

// File: rtl/ushift_reg.sv
// Parametrised universal shift register with counted burst shifting.
// Optional wrap-around rotate is compiled in with `define USHIFT_ROTATE_EN.
module ushift_reg
  import ushift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CP,
  input  logic             MR,
  inout  wire  [WIDTH-1:0] IO,
  ushift_if.slave          bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] shreg;
  logic             ser_msb;
  logic             ser_lsb;
  logic             engaged;
  logic             shift_en;
  logic             shift_dir;
  logic             busy;
  logic             done;

  function automatic logic [WIDTH-1:0] toward_msb(logic [WIDTH-1:0] r, logic in_bit);
    return {r[WIDTH-2:0], in_bit};
  endfunction

  function automatic logic [WIDTH-1:0] toward_lsb(logic [WIDTH-1:0] r, logic in_bit);
    return {in_bit, r[WIDTH-1:1]};
  endfunction

`ifdef USHIFT_ROTATE_EN
  assign ser_msb = bus.ROT ? shreg[WIDTH-1] : bus.DSL;
  assign ser_lsb = bus.ROT ? shreg[0]       : bus.DSR;
`else
  logic rot_unused;
  assign rot_unused = bus.ROT;
  assign ser_msb    = bus.DSL;
  assign ser_lsb    = bus.DSR;
`endif

  ushift_burst_ctrl #(
    .CW(CW)
  ) u_burst (
    .clk       (CP),
    .rst       (MR),
    .start     (bus.START),
    .dir       (bus.DIR),
    .cnt       (bus.CNT),
    .busy      (busy),
    .done      (done),
    .engaged   (engaged),
    .shift_en  (shift_en),
    .shift_dir (shift_dir)
  );

  always_ff @(posedge CP) begin
    if (MR) begin
      shreg <= '0;
    end else if (engaged) begin
      if (shift_en) begin
        if (shift_dir == DIR_LSB) shreg <= toward_lsb(shreg, ser_lsb);
        else                      shreg <= toward_msb(shreg, ser_msb);
      end
    end else begin
      unique case (mode_e'(bus.S))
        SHL_MSB: shreg <= toward_msb(shreg, ser_msb);
        SHR_LSB: shreg <= toward_lsb(shreg, ser_lsb);
        LOAD:    shreg <= IO;
        default: ;
      endcase
    end
  end

  // With both enables low IO carries shreg, so a load in that state holds
  assign IO       = (bus.N_OE == 2'b00) ? shreg : {WIDTH{1'bz}};
  assign bus.Q0   = shreg[0];
  assign bus.QMSB = shreg[WIDTH-1];
  assign bus.BUSY = busy;
  assign bus.DONE = done;

endmodule

// File: tb/tb_ushift_reg.sv
// Self-checking bench for ushift_reg (WIDTH=8): directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_ushift_reg;

  localparam int W = 8;

  logic       CP;
  logic       MR;
  wire  [7:0] io;
  logic [7:0] tb_io;
  logic       tb_drive;

  int n_vec;
  int n_err;

  // Behavioural model state
  logic [7:0] m_reg;
  int         m_left;
  logic       m_dir;
  logic       m_done;

  ushift_if #(.WIDTH(W)) bus ();

  assign io = tb_drive ? tb_io : 8'bzzzzzzzz;

  ushift_reg #(.WIDTH(W)) dut (
    .CP  (CP),
    .MR  (MR),
    .IO  (io),
    .bus (bus)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  function automatic logic [7:0] m_shift(logic [7:0] r, logic to_lsb, logic dsl, logic dsr, logic rot);
    int v;
    int in_b;
    v = int'(r);
    if (!to_lsb) begin
      in_b = int'(dsl);
`ifdef USHIFT_ROTATE_EN
      if (rot) in_b = v / 128;
`endif
      return 8'((v * 2 + in_b) % 256);
    end else begin
      in_b = int'(dsr);
`ifdef USHIFT_ROTATE_EN
      if (rot) in_b = v % 2;
`endif
      return 8'(v / 2 + in_b * 128);
    end
  endfunction

  // Advance one clock edge, updating the model from the inputs seen at that edge.
  task automatic step();
    logic [7:0] nreg;
    int         nleft;
    logic       ndir;
    logic       ndone;
    logic [7:0] iov;
    nreg  = m_reg;
    nleft = m_left;
    ndir  = m_dir;
    ndone = 1'b0;
    iov   = (bus.N_OE == 2'b00) ? m_reg : (tb_drive ? tb_io : 8'h00);
    if (MR) begin
      nreg = 8'h00; nleft = 0; ndir = 1'b0;
    end else if (m_left > 0) begin
      nreg  = m_shift(m_reg, m_dir, bus.DSL, bus.DSR, bus.ROT);
      nleft = m_left - 1;
      if (nleft == 0) ndone = 1'b1;
    end else if (bus.START) begin
      nleft = int'(bus.CNT);
      ndir  = bus.DIR;
      if (nleft == 0) ndone = 1'b1;
    end else begin
      case (bus.S)
        2'b01:   nreg = m_shift(m_reg, 1'b0, bus.DSL, bus.DSR, bus.ROT);
        2'b10:   nreg = m_shift(m_reg, 1'b1, bus.DSL, bus.DSR, bus.ROT);
        2'b11:   nreg = iov;
        default: ;
      endcase
    end
    @(posedge CP);
    #1;
    m_reg  = nreg;
    m_left = nleft;
    m_dir  = ndir;
    m_done = ndone;
  endtask

  task automatic load(input logic [7:0] v);
    bus.N_OE = 2'b11;
    tb_drive = 1'b1;
    tb_io    = v;
    bus.S    = 2'b11;
    step();
    bus.S    = 2'b00;
  endtask

  task automatic show_reg();
    bus.N_OE = 2'b00;
    tb_drive = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    show_reg();
    n_vec++;
    if (io !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      $display("FAIL reset_state: io=%h busy=%b done=%b, want io=00 busy=0 done=0", io, bus.BUSY, bus.DONE);
      n_err++;
    end
    load(8'h5A);
    bus.START = 1'b1; bus.CNT = 4'd5; bus.DIR = 1'b0; bus.DSL = 1'b0;
    step();
    bus.START = 1'b0;
    step();
    step();
    show_reg();
    n_vec++;
    if (io !== 8'h68 || bus.BUSY !== 1'b1) begin
      $display("FAIL reset_midburst_pre: io=%h busy=%b, want io=68 busy=1", io, bus.BUSY);
      n_err++;
    end
    MR = 1'b1;
    step();
    MR = 1'b0;
    n_vec++;
    if (io !== 8'h00 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      $display("FAIL reset_midburst: io=%h busy=%b done=%b, want io=00 busy=0 done=0", io, bus.BUSY, bus.DONE);
      n_err++;
    end
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (bus.DONE !== 1'b0 || io !== 8'h00) begin
        $display("FAIL reset_no_done: cycle=%0d done=%b io=%h, want done=0 io=00", i, bus.DONE, io);
        n_err++;
      end
    end
  endtask

  task automatic test_load_drive();
    load(8'hA5);
    show_reg();
    n_vec++;
    if (io !== 8'hA5 || bus.Q0 !== 1'b1 || bus.QMSB !== 1'b1) begin
      $display("FAIL load_drive: io=%h q0=%b qmsb=%b, want io=a5 q0=1 qmsb=1", io, bus.Q0, bus.QMSB);
      n_err++;
    end
    // Held load while driving keeps the value
    bus.S = 2'b11;
    step();
    bus.S = 2'b00;
    n_vec++;
    if (io !== 8'hA5) begin
      $display("FAIL load_held: io=%h, want a5", io);
      n_err++;
    end
    // DUT must release IO: the bench value must appear undisturbed
    bus.N_OE = 2'b01; tb_drive = 1'b1; tb_io = 8'h3C;
    #1;
    n_vec++;
    if (io !== 8'h3C) begin
      $display("FAIL io_release: io=%h, want 3c (bench-driven)", io);
      n_err++;
    end
    bus.S = 2'b11;
    step();
    bus.S = 2'b00;
    n_vec++;
    if (bus.Q0 !== 1'b0 || bus.QMSB !== 1'b0) begin
      $display("FAIL load_3c: q0=%b qmsb=%b, want 0 0", bus.Q0, bus.QMSB);
      n_err++;
    end
  endtask

  task automatic test_shift();
    load(8'h80);
    show_reg();
    bus.S = 2'b01; bus.DSL = 1'b1;
    step();
    n_vec++;
    if (io !== 8'h01 || bus.QMSB !== 1'b0) begin
      $display("FAIL shift_msb: io=%h qmsb=%b, want 01 0", io, bus.QMSB);
      n_err++;
    end
    bus.S = 2'b10; bus.DSR = 1'b1;
    step();
    bus.S = 2'b00;
    n_vec++;
    if (io !== 8'h80 || bus.QMSB !== 1'b1) begin
      $display("FAIL shift_lsb: io=%h qmsb=%b, want 80 1", io, bus.QMSB);
      n_err++;
    end
  endtask

  task automatic test_burst();
    load(8'hF0);
    bus.N_OE = 2'b11; tb_drive = 1'b1; tb_io = 8'hFF; bus.S = 2'b11;
    bus.START = 1'b1; bus.CNT = 4'd3; bus.DIR = 1'b1; bus.DSR = 1'b0;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
        $display("FAIL burst_busy: cycle=%0d busy=%b done=%b, want 1 0", i, bus.BUSY, bus.DONE);
        n_err++;
      end
      step();
    end
    show_reg();
    n_vec++;
    if (io !== 8'h1E || bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
      $display("FAIL burst_end: io=%h busy=%b done=%b, want 1e 0 1", io, bus.BUSY, bus.DONE);
      n_err++;
    end
    // Restart inside the DONE cycle
    bus.START = 1'b1; bus.CNT = 4'd2; bus.DIR = 1'b0; bus.DSL = 1'b1;
    step();
    bus.START = 1'b0;
    n_vec++;
    if (bus.BUSY !== 1'b1 || bus.DONE !== 1'b0) begin
      $display("FAIL burst_b2b_accept: busy=%b done=%b, want 1 0", bus.BUSY, bus.DONE);
      n_err++;
    end
    step();
    step();
    n_vec++;
    if (io !== 8'h7B || bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
      $display("FAIL burst_b2b_end: io=%h busy=%b done=%b, want 7b 0 1", io, bus.BUSY, bus.DONE);
      n_err++;
    end
    bus.S = 2'b00;
    step();
    n_vec++;
    if (bus.DONE !== 1'b0) begin
      $display("FAIL done_pulse: done=%b, want 0", bus.DONE);
      n_err++;
    end
  endtask

  task automatic test_zero_oversize();
    show_reg();
    bus.START = 1'b1; bus.CNT = 4'd0;
    step();
    bus.START = 1'b0;
    n_vec++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b1 || io !== 8'h7B) begin
      $display("FAIL cnt0: busy=%b done=%b io=%h, want 0 1 7b", bus.BUSY, bus.DONE, io);
      n_err++;
    end
    step();
    n_vec++;
    if (bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin
      $display("FAIL cnt0_after: busy=%b done=%b, want 0 0", bus.BUSY, bus.DONE);
      n_err++;
    end
    bus.START = 1'b1; bus.CNT = 4'd9; bus.DIR = 1'b0; bus.DSL = 1'b1;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (bus.BUSY !== 1'b1) begin
        $display("FAIL cnt9_busy: cycle=%0d busy=%b, want 1", i, bus.BUSY);
        n_err++;
      end
      step();
    end
    n_vec++;
    if (io !== 8'hFF || bus.BUSY !== 1'b0 || bus.DONE !== 1'b1) begin
      $display("FAIL cnt9_end: io=%h busy=%b done=%b, want ff 0 1", io, bus.BUSY, bus.DONE);
      n_err++;
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_a;
    logic [7:0] exp_b;
`ifdef USHIFT_ROTATE_EN
    exp_a = 8'h80; exp_b = 8'h01;
`else
    exp_a = 8'h00; exp_b = 8'h00;
`endif
    load(8'h01);
    show_reg();
    bus.ROT = 1'b1; bus.DSR = 1'b0; bus.DSL = 1'b0; bus.S = 2'b10;
    step();
    n_vec++;
    if (io !== exp_a) begin
      $display("FAIL rotate_lsb: io=%h, want %h", io, exp_a);
      n_err++;
    end
    load(8'h80);
    show_reg();
    bus.S = 2'b01;
    step();
    bus.S = 2'b00; bus.ROT = 1'b0;
    n_vec++;
    if (io !== exp_b) begin
      $display("FAIL rotate_msb: io=%h, want %h", io, exp_b);
      n_err++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      MR        = ($urandom_range(0, 49) == 0);
      bus.S     = 2'($urandom_range(0, 3));
      bus.N_OE  = 2'($urandom_range(0, 3));
      bus.DSL   = 1'($urandom_range(0, 1));
      bus.DSR   = 1'($urandom_range(0, 1));
      bus.ROT   = 1'($urandom_range(0, 1));
      bus.START = ($urandom_range(0, 3) == 0);
      bus.DIR   = 1'($urandom_range(0, 1));
      bus.CNT   = 4'($urandom_range(0, 11));
      tb_drive  = (bus.N_OE != 2'b00);
      tb_io     = 8'($urandom);
      step();
      n_vec++;
      if (bus.BUSY !== (m_left > 0) || bus.DONE !== m_done ||
          bus.Q0 !== m_reg[0] || bus.QMSB !== m_reg[7] ||
          io !== (tb_drive ? tb_io : m_reg)) begin
        $display("FAIL random[%0d]: busy=%b done=%b q0=%b qmsb=%b io=%h, want busy=%b done=%b reg=%h io=%h",
                 i, bus.BUSY, bus.DONE, bus.Q0, bus.QMSB, io,
                 (m_left > 0), m_done, m_reg, (tb_drive ? tb_io : m_reg));
        n_err++;
      end
    end
    MR = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    m_reg = 8'h00; m_left = 0; m_dir = 1'b0; m_done = 1'b0;
    MR = 1'b1; tb_drive = 1'b0; tb_io = 8'h00;
    bus.S = 2'b00; bus.N_OE = 2'b11; bus.DSL = 1'b0; bus.DSR = 1'b0;
    bus.ROT = 1'b0; bus.START = 1'b0; bus.DIR = 1'b0; bus.CNT = 4'd0;
    step();
    step();
    MR = 1'b0;
    test_reset();
    test_load_drive();
    test_shift();
    test_burst();
    test_zero_oversize();
    test_rotate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ushift_reg.md
# ushift_reg

Parametrised universal shift register: generalised, wider successor to the 8-bit 74299-style part. Adds a WIDTH parameter, a counted burst-shift engine with BUSY/DONE handshake, and an optional rotate mode. Serves as the chainable shift/serialise element for wide datapaths and for serial links where the controller issues "shift n bits" and waits for completion.

## Interface
- WIDTH, 8, register width in bits, ≥2
- CW, $clog2(WIDTH+1), width of CNT (derived, not overridden)
- CP  in  1  clock; all state changes on posedge
- MR  in  1  reset; synchronous, active-high
- S  in  2  mode: 00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load
- N_OE  in  2  IO output enable; IO is driven only when both bits are 0
- DSL  in  1  serial input into bit 0 on a toward-MSB shift
- DSR  in  1  serial input into bit WIDTH-1 on a toward-LSB shift
- ROT  in  1  rotate select; active only when USHIFT_ROTATE_EN is defined
- START  in  1  burst request; sampled only in IDLE
- DIR  in  1  burst direction: 0 toward MSB, 1 toward LSB
- CNT  in  CW  burst length in single-bit shifts
- IO  inout  WIDTH  parallel data; reg when driven, Z otherwise
- Q0  out  1  reg[0]
- QMSB  out  1  reg[WIDTH-1]
- BUSY  out  1  burst in progress
- DONE  out  1  one-cycle burst-complete pulse

## Operation
- Priority at each edge: MR > burst engine (START accepted or BUSY) > S.
- Toward-MSB shift: reg <= {reg[WIDTH-2:0], DSL}. Toward-LSB shift: reg <= {DSR, reg[WIDTH-1:1]}.
- Load (S=11) captures IO. If N_OE=00 during load, IO carries reg, so the value is held.
- IO, Q0, and QMSB are combinational from reg. No extra latency.
- FSM states:
  - IDLE: START=1 loads the counter with CNT and records DIR. CNT>0 moves to SHIFT. CNT=0 stays in IDLE and raises DONE next cycle.
  - SHIFT: shifts one bit per edge in the latched direction, using DSL or DSR live each cycle. Decrements the counter. When the counter reaches 1, the state returns to IDLE and DONE is registered.
- In SHIFT, S, START, DIR, and CNT are ignored. The burst is not abortable except by MR.
- CNT may exceed WIDTH. Exactly CNT shifts occur, with no clamping.
- BUSY = (state==SHIFT). DONE is a registered pulse, high for exactly one cycle.
- Reset outputs: reg=0, Q0=0, QMSB=0, BUSY=0, DONE=0, state IDLE, counter 0. IO=Z unless N_OE=00, in which case IO drives 0.

## Timing
- START accepted at edge k with CNT=n>0:
  - BUSY is high from after edge k through edge k+n.
  - Shifts occur on edges k+1 through k+n.
  - DONE is high during the cycle after edge k+n.
- CNT=0: no shift, BUSY stays low, and DONE is high during the cycle after edge k.
- Back-to-back: START in the DONE cycle (state is IDLE) is accepted. Zero bubble beyond that cycle.
- MR mid-burst: at the next edge all state clears, with no DONE and no further shifts.
- Normal S-mode operations take effect at the same edge they are sampled.

## Configuration
- USHIFT_ROTATE_EN defined: ROT=1 replaces the serial input with wrap-around.
  - Toward-MSB takes reg[WIDTH-1] into bit 0.
  - Toward-LSB takes reg[0] into bit WIDTH-1.
  - Applies to both S-mode and burst shifts. ROT is sampled each shift edge.
- Undefined: the ROT port remains but is ignored. Serial inputs are always DSL and DSR.

## Structure
- Package ushift_pkg holds:
  - the mode enum (HOLD, SHL_MSB, SHR_LSB, LOAD), with encodings matching S;
  - the FSM state enum (IDLE, SHIFT);
  - the DIR constants.
- One sub-module, ushift_burst_ctrl, holds the FSM, counter, BUSY/DONE, and latched DIR. It outputs a shift-enable and direction to the top, which owns reg and IO.

## Test plan
- Reset: MR=1 mid-burst (CNT=5, two shifts done) → next cycle reg=0, BUSY=0, DONE=0, and DONE stays 0 afterwards.
- Load/drive: N_OE=11, IO=0xA5, S=11 → reg=0xA5. Then N_OE=00, S=00 → IO reads 0xA5, Q0=1, QMSB=1. N_OE=01 → IO=Z.
- Shift: reg=0x80, S=01, DSL=1 → 0x01, QMSB=0. Then S=10, DSR=1 → 0x80.
- Burst: reg=0xF0, START with CNT=3, DIR=1, DSR=0, and S=11 held with IO=0xFF → BUSY for 3 cycles, reg=0x1E, DONE a single pulse, S ignored. START again in the DONE cycle → accepted.
- Zero and oversize count:
  - CNT=0 → DONE next cycle, BUSY never high, reg unchanged.
  - CNT=9 with WIDTH=8, DIR=0, DSL=1 → 9 BUSY cycles, reg=0xFF.
- Rotate: reg=0x01, ROT=1, S=10 → 0x80 with USHIFT_ROTATE_EN defined. Without the macro (DSR=0) → 0x00.
